// File: rtl/apb_request_arbiter_pkg.sv
// Shared types and widths for the multi-requester APB master.
package apb_pkg;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam logic [SEL_W-1:0] SEL_NONE = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;
endpackage

// File: rtl/apb_request_arbiter_if.sv
// Requester-side and APB-side signals of the arbiter; master = arbiter view.
interface apb_request_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
) ();
    import apb_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_write;
    logic [SEL_W*NUM_REQ-1:0]  req_sel;
    logic [ADDR_W*NUM_REQ-1:0] req_addr;
    logic [DATA_W*NUM_REQ-1:0] req_wdata;
    logic [DATA_W*NUM_REQ-1:0] req_wait_cycles;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      write;
    logic [SEL_W-1:0]          sel;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         wdata;
    logic [DATA_W-1:0]         wait_cycles;
    logic                      enable;
    logic                      ready;
    logic [DATA_W-1:0]         rdata;

    modport master (
        input  req, req_write, req_sel, req_addr, req_wdata, req_wait_cycles,
        input  ready, rdata,
        output grant, done, err, rsp_rdata,
        output write, sel, addr, wdata, wait_cycles, enable
    );

    modport slave (
        output req, req_write, req_sel, req_addr, req_wdata, req_wait_cycles,
        output ready, rdata,
        input  grant, done, err, rsp_rdata,
        input  write, sel, addr, wdata, wait_cycles, enable
    );
endinterface

// File: rtl/apb_request_arbiter_rr_arbiter.sv
// Round-robin picker: searches from the last winner + 1, skipping masked requesters.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic               any_req_o
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W-1:0]   idx;
    logic [NUM_REQ-1:0] eligible;
    logic               found;

    assign eligible  = req_i & ~mask_i;
    assign any_req_o = |eligible;

    always_comb begin
        winner_o = '0;
        ptr_d    = ptr_q;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && eligible[idx]) begin
                winner_o[idx] = 1'b1;
                ptr_d         = idx;
                found         = 1'b1;
            end
        end
    end

    // Pointer starts at the last requester so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_W'(NUM_REQ - 1);
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/apb_request_arbiter.sv
// Shares one APB master bus among NUM_REQ requesters with round-robin grant and timeout.
module apb_request_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    apb_request_arbiter_if.master bus
);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic [NUM_REQ-1:0]  grant_q, done_q, err_q;
    logic [DATA_W-1:0]   rsp_rdata_q, wdata_q, wait_q;
    logic                write_q, enable_q;
    logic [SEL_W-1:0]    sel_q;
    logic [ADDR_W-1:0]   addr_q;

    logic [NUM_REQ-1:0]  winner;
    logic                any_req;
    logic                advance;
    logic                w_write;
    logic [SEL_W-1:0]    w_sel;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata, w_wait;

    // Current owner and the just-completed requester are both excluded.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (reset),
        .req_i     (bus.req),
        .mask_i    (done_q | grant_q),
        .advance_i (advance),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_comb begin
        w_write = 1'b0;
        w_sel   = SEL_NONE;
        w_addr  = '0;
        w_wdata = '0;
        w_wait  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                w_write = bus.req_write[i];
                w_sel   = bus.req_sel[i*SEL_W +: SEL_W];
                w_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                w_wait  = bus.req_wait_cycles[i*DATA_W +: DATA_W];
            end
        end
    end

    assign advance = any_req &&
                     ((state_q == S_IDLE) ||
                      (state_q == S_ACCESS && bus.ready && w_sel != SEL_NONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rsp_rdata_q <= '0;
            write_q     <= 1'b0;
            sel_q       <= SEL_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            enable_q    <= 1'b0;
        end else begin
            done_q      <= '0;
            err_q       <= '0;
            rsp_rdata_q <= '0;
            case (state_q)
                S_IDLE: begin
                    sel_q    <= SEL_NONE;
                    enable_q <= 1'b0;
                    grant_q  <= '0;
                    if (any_req) begin
                        if (w_sel == SEL_NONE) begin
                            done_q <= winner;
                            err_q  <= winner;
                        end else begin
                            write_q <= w_write;
                            sel_q   <= w_sel;
                            addr_q  <= w_addr;
                            wdata_q <= w_wdata;
                            wait_q  <= w_wait;
                            grant_q <= winner;
                            cnt_q   <= '0;
                            state_q <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    enable_q <= 1'b1;
                    cnt_q    <= cnt_q + 8'd1;
                    state_q  <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (bus.ready) begin
                        done_q      <= grant_q;
                        rsp_rdata_q <= write_q ? '0 : bus.rdata;
                        enable_q    <= 1'b0;
                        // An invalid-sel winner is left for IDLE so its done never collides.
                        if (any_req && w_sel != SEL_NONE) begin
                            write_q <= w_write;
                            sel_q   <= w_sel;
                            addr_q  <= w_addr;
                            wdata_q <= w_wdata;
                            wait_q  <= w_wait;
                            grant_q <= winner;
                            cnt_q   <= '0;
                            state_q <= S_SETUP;
                        end else begin
                            grant_q <= '0;
                            sel_q   <= SEL_NONE;
                            state_q <= S_IDLE;
                        end
                    end else if (cnt_q == TIMEOUT_C) begin
                        done_q   <= grant_q;
                        err_q    <= grant_q;
                        grant_q  <= '0;
                        sel_q    <= SEL_NONE;
                        enable_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.write       = write_q;
    assign bus.sel         = sel_q;
    assign bus.addr        = addr_q;
    assign bus.wdata       = wdata_q;
    assign bus.wait_cycles = wait_q;
    assign bus.enable      = enable_q;
endmodule

// File: tb/tb_apb_request_arbiter.sv
// Directed bench for apb_request_arbiter: two requesters, TIMEOUT_CYCLES = 4.
module tb_apb_request_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    apb_request_arbiter_if #(.NUM_REQ(2)) bus ();

    apb_request_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic w, input logic [1:0] s,
                           input logic [7:0] a, input logic [7:0] d, input logic [7:0] wc);
        bus.req_write[r]             = w;
        bus.req_sel[r*2 +: 2]        = s;
        bus.req_addr[r*8 +: 8]       = a;
        bus.req_wdata[r*8 +: 8]      = d;
        bus.req_wait_cycles[r*8 +: 8] = wc;
        bus.req[r]                   = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_write = '0; bus.req_sel = '0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wait_cycles = '0; bus.ready = 1'b0; bus.rdata = '0;
        reset = 1'b0;
        step(); step();
        checks++;
        if ({bus.grant, bus.done, bus.err, bus.rsp_rdata, bus.write, bus.sel, bus.addr,
             bus.wdata, bus.wait_cycles, bus.enable} !== 42'd0) begin
            errors++; $display("FAIL reset_outputs got grant=%b done=%b sel=%h en=%b exp all zero",
                               bus.grant, bus.done, bus.sel, bus.enable);
        end
        reset = 1'b1;
        step();
        checks++;
        if (bus.grant !== 2'b00 || bus.enable !== 1'b0) begin
            errors++; $display("FAIL reset_idle got grant=%b en=%b exp 00 0", bus.grant, bus.enable);
        end
    endtask

    task automatic test_single_read();
        set_req(0, 1'b0, 2'd1, 8'h10, 8'h00, 8'h00);
        bus.rdata = 8'hA5;
        step();
        checks++;
        if (bus.sel !== 2'd1 || bus.enable !== 1'b0 || bus.grant !== 2'b01 || bus.addr !== 8'h10) begin
            errors++; $display("FAIL read_setup got sel=%0d en=%b grant=%b addr=%h exp 1 0 01 10",
                               bus.sel, bus.enable, bus.grant, bus.addr);
        end
        step();
        checks++;
        if (bus.enable !== 1'b1 || bus.sel !== 2'd1) begin
            errors++; $display("FAIL read_access got en=%b sel=%0d exp 1 1", bus.enable, bus.sel);
        end
        bus.ready = 1'b1;
        step();
        checks++;
        if (bus.done !== 2'b01 || bus.err !== 2'b00 || bus.rsp_rdata !== 8'hA5) begin
            errors++; $display("FAIL read_done got done=%b err=%b rdata=%h exp 01 00 a5",
                               bus.done, bus.err, bus.rsp_rdata);
        end
        checks++;
        if (bus.grant !== 2'b00 || bus.enable !== 1'b0 || bus.sel !== 2'd0) begin
            errors++; $display("FAIL read_release got grant=%b en=%b sel=%0d exp 00 0 0",
                               bus.grant, bus.enable, bus.sel);
        end
        bus.req[0] = 1'b0; bus.ready = 1'b0;
        step();
        checks++;
        if (bus.done !== 2'b00 || bus.rsp_rdata !== 8'h00) begin
            errors++; $display("FAIL read_pulse got done=%b rdata=%h exp 00 00", bus.done, bus.rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        set_req(0, 1'b0, 2'd1, 8'h20, 8'h00, 8'h00);
        set_req(1, 1'b1, 2'd2, 8'h30, 8'h5A, 8'h00);
        bus.ready = 1'b1; bus.rdata = 8'h11;
        do_reset();
        step();
        checks++;
        if (bus.grant !== 2'b01) begin
            errors++; $display("FAIL b2b_first_grant got %b exp 01", bus.grant);
        end
        step();
        step();
        checks++;
        if (bus.done !== 2'b01 || bus.rsp_rdata !== 8'h11 || bus.grant !== 2'b10 ||
            bus.sel !== 2'd2 || bus.enable !== 1'b0 || bus.addr !== 8'h30) begin
            errors++; $display("FAIL b2b_switch got done=%b rd=%h grant=%b sel=%0d en=%b addr=%h exp 01 11 10 2 0 30",
                               bus.done, bus.rsp_rdata, bus.grant, bus.sel, bus.enable, bus.addr);
        end
        bus.req[0] = 1'b0;
        step();
        checks++;
        if (bus.enable !== 1'b1 || bus.grant !== 2'b10 || bus.write !== 1'b1 || bus.wdata !== 8'h5A) begin
            errors++; $display("FAIL b2b_second_access got en=%b grant=%b wr=%b wd=%h exp 1 10 1 5a",
                               bus.enable, bus.grant, bus.write, bus.wdata);
        end
        set_req(0, 1'b0, 2'd1, 8'h21, 8'h00, 8'h00);
        bus.rdata = 8'hC3;
        step();
        checks++;
        if (bus.done !== 2'b10 || bus.rsp_rdata !== 8'h00 || bus.grant !== 2'b01 || bus.addr !== 8'h21) begin
            errors++; $display("FAIL b2b_third_grant got done=%b rd=%h grant=%b addr=%h exp 10 00 01 21",
                               bus.done, bus.rsp_rdata, bus.grant, bus.addr);
        end
        bus.req[1] = 1'b0;
        step();
        step();
        checks++;
        if (bus.done !== 2'b01 || bus.rsp_rdata !== 8'hC3 || bus.grant !== 2'b00) begin
            errors++; $display("FAIL b2b_third_done got done=%b rd=%h grant=%b exp 01 c3 00",
                               bus.done, bus.rsp_rdata, bus.grant);
        end
        bus.req[0] = 1'b0; bus.ready = 1'b0;
        step();
    endtask

    task automatic test_wait_states();
        set_req(1, 1'b1, 2'd3, 8'h44, 8'h77, 8'h03);
        bus.rdata = 8'hEE;
        step();
        checks++;
        if (bus.grant !== 2'b10 || bus.wait_cycles !== 8'h03 || bus.write !== 1'b1 || bus.enable !== 1'b0) begin
            errors++; $display("FAIL wait_setup got grant=%b wc=%h wr=%b en=%b exp 10 03 1 0",
                               bus.grant, bus.wait_cycles, bus.write, bus.enable);
        end
        bus.req_addr[15:8] = 8'hFF;
        bus.req_wdata[15:8] = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (bus.enable !== 1'b1 || bus.addr !== 8'h44 || bus.wdata !== 8'h77 || bus.done !== 2'b00) begin
                errors++; $display("FAIL wait_access%0d got en=%b addr=%h wd=%h done=%b exp 1 44 77 00",
                                   k, bus.enable, bus.addr, bus.wdata, bus.done);
            end
        end
        bus.ready = 1'b1;
        step();
        checks++;
        if (bus.done !== 2'b10 || bus.err !== 2'b00 || bus.rsp_rdata !== 8'h00 || bus.enable !== 1'b0) begin
            errors++; $display("FAIL wait_done got done=%b err=%b rd=%h en=%b exp 10 00 00 0",
                               bus.done, bus.err, bus.rsp_rdata, bus.enable);
        end
        bus.req[1] = 1'b0; bus.ready = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        set_req(0, 1'b0, 2'd2, 8'h55, 8'h00, 8'h00);
        bus.rdata = 8'h99;
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (bus.enable !== 1'b1 || bus.done !== 2'b00) begin
                errors++; $display("FAIL timeout_access%0d got en=%b done=%b exp 1 00", k, bus.enable, bus.done);
            end
        end
        step();
        checks++;
        if (bus.done !== 2'b01 || bus.err !== 2'b01 || bus.rsp_rdata !== 8'h00) begin
            errors++; $display("FAIL timeout_done got done=%b err=%b rd=%h exp 01 01 00",
                               bus.done, bus.err, bus.rsp_rdata);
        end
        checks++;
        if (bus.sel !== 2'd0 || bus.enable !== 1'b0 || bus.grant !== 2'b00) begin
            errors++; $display("FAIL timeout_release got sel=%0d en=%b grant=%b exp 0 0 00",
                               bus.sel, bus.enable, bus.grant);
        end
        bus.req[0] = 1'b0;
        step();
    endtask

    task automatic test_invalid_sel();
        set_req(1, 1'b0, 2'd0, 8'h66, 8'h00, 8'h00);
        step();
        checks++;
        if (bus.done !== 2'b10 || bus.err !== 2'b10) begin
            errors++; $display("FAIL badsel_done got done=%b err=%b exp 10 10", bus.done, bus.err);
        end
        checks++;
        if (bus.sel !== 2'd0 || bus.enable !== 1'b0 || bus.grant !== 2'b00) begin
            errors++; $display("FAIL badsel_nobus got sel=%0d en=%b grant=%b exp 0 0 00",
                               bus.sel, bus.enable, bus.grant);
        end
        bus.req[1] = 1'b0;
        step();
        checks++;
        if (bus.done !== 2'b00 || bus.err !== 2'b00 || bus.sel !== 2'd0) begin
            errors++; $display("FAIL badsel_after got done=%b err=%b sel=%0d exp 00 00 0",
                               bus.done, bus.err, bus.sel);
        end
    endtask

    task automatic test_reset_mid_access();
        set_req(1, 1'b0, 2'd1, 8'h70, 8'h00, 8'h00);
        step();
        step();
        checks++;
        if (bus.enable !== 1'b1 || bus.grant !== 2'b10) begin
            errors++; $display("FAIL midrst_access got en=%b grant=%b exp 1 10", bus.enable, bus.grant);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.grant, bus.done, bus.err, bus.rsp_rdata, bus.write, bus.sel, bus.addr,
             bus.wdata, bus.wait_cycles, bus.enable} !== 42'd0) begin
            errors++; $display("FAIL midrst_async got grant=%b sel=%0d addr=%h en=%b exp all zero",
                               bus.grant, bus.sel, bus.addr, bus.enable);
        end
        bus.ready = 1'b1;
        step();
        checks++;
        if (bus.done !== 2'b00 || bus.enable !== 1'b0) begin
            errors++; $display("FAIL midrst_nodone got done=%b en=%b exp 00 0", bus.done, bus.enable);
        end
        bus.ready = 1'b0;
        set_req(0, 1'b0, 2'd2, 8'h71, 8'h00, 8'h00);
        reset = 1'b1;
        step();
        checks++;
        if (bus.grant !== 2'b01 || bus.addr !== 8'h71) begin
            errors++; $display("FAIL midrst_priority got grant=%b addr=%h exp 01 71", bus.grant, bus.addr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_wait_states();
        test_timeout();
        test_invalid_sel();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
